out_reg_cell: RTL and testbench

- Fabric-to-pad output register cell for the AP3 IO tile; the transmit-side counterpart of the pad-to-fabric input register cell.
- Registers (or bypasses) fabric output data onto the pad and generates the pad output-enable.
- The output-enable path is driven by a small turn-off state machine. It holds the driver on with frozen data for a programmable number of cycles after the fabric drops its enable request, which gives bus turnaround without glitching the pad.
- Whitebox model for VPR timing annotation.

---
 rtl/out_reg_cell_pkg.sv | 18 +
 rtl/out_reg_cell_oe_turnoff_fsm.sv | 80 ++++++++
 rtl/out_reg_cell.sv | 49 ++++
 tb/tb_out_reg_cell.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/out_reg_cell_pkg.sv
// Shared definitions for the IO-tile output register cell: turn-off FSM
// state encoding, counter width and the 2:1 select primitive.
package out_reg_cell_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        DRIVE   = 2'b01,
        TURNOFF = 2'b10
    } oe_state_e;

    localparam int CNT_W = 4;

    // Select primitive shared by the data (OSEL) and enable (ESEL) paths.
    function automatic logic mux2(input logic sel, input logic in0, input logic in1);
        return sel ? in1 : in0;
    endfunction

endpackage

// File: rtl/out_reg_cell_oe_turnoff_fsm.sv
// Output-enable turn-off state machine: keeps the pad driver on with frozen
// data for a programmable number of cycles after the enable request drops.
module oe_turnoff_fsm
    import out_reg_cell_pkg::*;
#(
    parameter int OE_TURNOFF_CYCLES = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      oe_req,
    input  logic      esel,
    output oe_state_e state,
    output logic      oe_drive,
    output logic      capture
);

    localparam logic [CNT_W-1:0] TURN_INIT =
        (OE_TURNOFF_CYCLES > 0) ? 4'(OE_TURNOFF_CYCLES - 1) : '0;

    oe_state_e        next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        if (!esel) begin
            next_state = IDLE;
            next_cnt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (oe_req) next_state = DRIVE;
                end
                DRIVE: begin
                    if (!oe_req) begin
                        if (OE_TURNOFF_CYCLES == 0) begin
                            next_state = IDLE;
                        end else begin
                            next_state = TURNOFF;
                            next_cnt   = TURN_INIT;
                        end
                    end
                end
                TURNOFF: begin
                    // Reassertion wins over counter expiry.
                    if (oe_req) begin
                        next_state = DRIVE;
                        next_cnt   = '0;
                    end else if (cnt == '0) begin
                        next_state = IDLE;
                    end else begin
                        next_cnt = cnt - 1'b1;
                    end
                end
                default: begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Data is frozen on the edge entering TURNOFF, while in it, and on its
    // expiry edge, so the pad never sees new data while the bus turns around.
    assign capture  = (next_state != TURNOFF) &&
                      !((state == TURNOFF) && (next_state == IDLE));
    assign oe_drive = (state != IDLE);

endmodule

// File: rtl/out_reg_cell.sv
// Fabric-to-pad output register cell: registered or bypassed data plus a
// pad output-enable with optional registered turn-off hold.
module out_reg_cell
    import out_reg_cell_pkg::*;
#(
    parameter int   OE_TURNOFF_CYCLES = 1,
    parameter logic RESET_VALUE       = 1'b0
) (
    input  logic OQC,
    input  logic QRT_N,
    input  logic F2A,
    input  logic OE_REQ,
    input  logic OSEL,
    input  logic ESEL,
    output logic OQZ,
    output logic OE_OUT,
    output logic TURN_BUSY
);

    oe_state_e fsm_state;
    logic      oe_drive;
    logic      capture;
    logic      data_q;

    oe_turnoff_fsm #(
        .OE_TURNOFF_CYCLES(OE_TURNOFF_CYCLES)
    ) u_fsm (
        .clk      (OQC),
        .rst_n    (QRT_N),
        .oe_req   (OE_REQ),
        .esel     (ESEL),
        .state    (fsm_state),
        .oe_drive (oe_drive),
        .capture  (capture)
    );

    always_ff @(posedge OQC or negedge QRT_N) begin
        if (!QRT_N) begin
            data_q <= RESET_VALUE;
        end else if (capture) begin
            data_q <= F2A;
        end
    end

    assign OQZ       = mux2(OSEL, F2A, data_q);
    assign OE_OUT    = mux2(ESEL, OE_REQ, oe_drive);
    assign TURN_BUSY = (fsm_state == TURNOFF);

endmodule

// File: tb/tb_out_reg_cell.sv
// Self-checking bench for out_reg_cell: three parameterisations share one
// stimulus stream and are compared against a cycle-level behavioural model.
module tb_out_reg_cell;

    logic oqc;
    logic qrt_n;
    logic f2a;
    logic oe_req;
    logic osel;
    logic esel;
    logic oqz[3];
    logic oe_out[3];
    logic turn_busy[3];

    int   errors = 0;
    int   checks = 0;

    // Per-instance parameters: turn-off hold length and reset value.
    int   n_cyc[3] = '{2, 3, 0};
    logic rv[3]    = '{1'b0, 1'b1, 1'b0};

    // Model state: driver on, consecutive low-request samples while on, data.
    logic m_active[3];
    int   m_lows[3];
    logic m_data[3];

    initial oqc = 1'b0;
    always #5 oqc = ~oqc;

    out_reg_cell #(.OE_TURNOFF_CYCLES(2), .RESET_VALUE(1'b0)) u_dut2 (
        .OQC(oqc), .QRT_N(qrt_n), .F2A(f2a), .OE_REQ(oe_req), .OSEL(osel), .ESEL(esel),
        .OQZ(oqz[0]), .OE_OUT(oe_out[0]), .TURN_BUSY(turn_busy[0])
    );
    out_reg_cell #(.OE_TURNOFF_CYCLES(3), .RESET_VALUE(1'b1)) u_dut3 (
        .OQC(oqc), .QRT_N(qrt_n), .F2A(f2a), .OE_REQ(oe_req), .OSEL(osel), .ESEL(esel),
        .OQZ(oqz[1]), .OE_OUT(oe_out[1]), .TURN_BUSY(turn_busy[1])
    );
    out_reg_cell #(.OE_TURNOFF_CYCLES(0), .RESET_VALUE(1'b0)) u_dut0 (
        .OQC(oqc), .QRT_N(qrt_n), .F2A(f2a), .OE_REQ(oe_req), .OSEL(osel), .ESEL(esel),
        .OQZ(oqz[2]), .OE_OUT(oe_out[2]), .TURN_BUSY(turn_busy[2])
    );

    // Driver stays on until more than N consecutive low samples were seen;
    // data is frozen on any low-request edge while on, if N > 0.
    always @(posedge oqc or negedge qrt_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!qrt_n) begin
                m_data[i]   = rv[i];
                m_active[i] = 1'b0;
                m_lows[i]   = 0;
            end else begin
                if (!(esel && !oe_req && m_active[i] && n_cyc[i] > 0)) m_data[i] = f2a;
                if (!esel) begin
                    m_active[i] = 1'b0;
                    m_lows[i]   = 0;
                end else if (oe_req) begin
                    m_active[i] = 1'b1;
                    m_lows[i]   = 0;
                end else if (m_active[i]) begin
                    m_lows[i] = m_lows[i] + 1;
                    if (m_lows[i] > n_cyc[i]) begin
                        m_active[i] = 1'b0;
                        m_lows[i]   = 0;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s at %0t: observed=%b expected=%b", tag, $time, observed, expected);
        end
    endtask

    task automatic check_all(input string tag);
        logic exp_oqz, exp_oe, exp_busy;
        for (int i = 0; i < 3; i++) begin
            exp_oqz  = osel ? m_data[i] : f2a;
            exp_oe   = esel ? m_active[i] : oe_req;
            exp_busy = esel && m_active[i] && (m_lows[i] > 0);
            chk($sformatf("%s_oqz%0d", tag, i), oqz[i], exp_oqz);
            chk($sformatf("%s_oe%0d", tag, i), oe_out[i], exp_oe);
            chk($sformatf("%s_busy%0d", tag, i), turn_busy[i], exp_busy);
        end
    endtask

    // Drive on the falling edge, check combinational view, then after the edge.
    task automatic step(input logic f, input logic r, input string tag);
        @(negedge oqc);
        f2a    = f;
        oe_req = r;
        #1 check_all({tag, "_comb"});
        @(posedge oqc);
        #1 check_all(tag);
    endtask

    task automatic reconfigure(input logic new_osel, input logic new_esel);
        @(negedge oqc);
        qrt_n = 1'b0;
        osel  = new_osel;
        esel  = new_esel;
        #1 check_all("cfg_reset");
        @(negedge oqc);
        qrt_n = 1'b1;
    endtask

    initial begin
        qrt_n  = 1'b0;
        osel   = 1'b1;
        esel   = 1'b1;
        f2a    = 1'b1;
        oe_req = 1'b1;

        repeat (3) @(posedge oqc);
        @(negedge oqc);
        check_all("reset");
        chk("reset_oqz_rv1", oqz[1], 1'b1);
        qrt_n = 1'b1;
        @(posedge oqc);
        #1 check_all("release");
        chk("release_oe_on", oe_out[0], 1'b1);

        // Registered data toggling with 1-cycle latency.
        step(1'b1, 1'b1, "data1");
        step(1'b0, 1'b1, "data0");
        step(1'b1, 1'b1, "data1b");

        // Turn-off: data frozen at 1 while request low and new data 0.
        step(1'b1, 1'b1, "pre_off");
        step(1'b0, 1'b0, "off_k");
        chk("off_k_frozen", oqz[0], 1'b1);
        chk("off_k_busy", turn_busy[0], 1'b1);
        chk("off_k_n0_oe", oe_out[2], 1'b0);
        step(1'b0, 1'b0, "off_k1");
        chk("off_k1_oe", oe_out[0], 1'b1);
        step(1'b0, 1'b0, "off_k2");
        chk("off_k2_oe", oe_out[0], 1'b0);
        step(1'b0, 1'b0, "off_k3");
        step(1'b1, 1'b0, "idle_data");

        // Reassert after a single low cycle.
        step(1'b1, 1'b1, "re_drive");
        step(1'b1, 1'b1, "re_drive2");
        step(1'b0, 1'b0, "re_low");
        step(1'b0, 1'b1, "re_high");
        chk("re_high_oe", oe_out[1], 1'b1);
        chk("re_high_capture", oqz[1], 1'b0);
        step(1'b1, 1'b1, "re_after");

        for (int n = 0; n < 150; n++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(0, 1)), "rand_reg");
        end

        // Asynchronous reset pulse in the middle of TURNOFF.
        step(1'b1, 1'b1, "ar_drive");
        step(1'b1, 1'b1, "ar_drive2");
        step(1'b0, 1'b0, "ar_turnoff");
        #1 qrt_n = 1'b0;
        #1 check_all("ar_async");
        chk("ar_async_oe", oe_out[1], 1'b0);
        chk("ar_async_oqz", oqz[1], 1'b1);
        #1 qrt_n = 1'b1;
        step(1'b0, 1'b0, "ar_idle");
        step(1'b1, 1'b1, "ar_drive3");

        reconfigure(1'b0, 1'b0);
        for (int n = 0; n < 60; n++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand_byp");
        end
        reconfigure(1'b1, 1'b0);
        for (int n = 0; n < 60; n++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand_oeb");
        end
        reconfigure(1'b0, 1'b1);
        for (int n = 0; n < 60; n++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand_db");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
